mux_nto1_stream: RTL and testbench

//  N-input, W-bit registered stream multiplexer with valid/ready handshakes.

---
 rtl/mux_nto1_stream.sv | 191 +++++++++++++++++++
 tb/tb_mux_nto1_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_stream
// Description : N-input, W-bit registered stream multiplexer with valid/ready
//               handshakes on every channel and on the output. The source
//               channel is chosen either by the sel port (mode=0) or by a
//               round-robin arbiter (mode=1). The output stage is a single
//               register slice: 1-cycle latency, full throughput when the
//               consumer drains and a producer pushes in the same cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   MUX_PARITY_EN - when defined, adds the out_parity port (even parity of
//                   out_data, registered alongside it). When undefined the
//                   port and its logic are absent.
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH      data width per channel
//   NUM_CH     number of input channels (2..16, any value, not only 2^n)
//   SEL_WIDTH  channel index width, must be >= clog2(NUM_CH)
// Ports:
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   mode       in   1              0 = fixed select via sel, 1 = round-robin
//   sel        in   SEL_WIDTH      channel select (mode=0 only)
//   in_valid   in   NUM_CH         per-channel valid
//   in_ready   out  NUM_CH         per-channel ready (combinational)
//   in_data    in   NUM_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   out_valid  out  1              output valid (registered)
//   out_ready  in   1              consumer ready
//   out_data   out  WIDTH          output data (registered)
//   out_chan   out  SEL_WIDTH      source channel of out_data (registered)
//   out_parity out  1              even parity of out_data (MUX_PARITY_EN)
// ============================================================================
module mux_nto1_stream #(
    parameter int WIDTH     = 64,
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_WIDTH-1:0]      sel,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]      out_chan
`ifdef MUX_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_WIDTH-1:0]  r_out_chan;
    logic [SEL_WIDTH-1:0]  r_rr_ptr;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_load;
    logic [NUM_CH-1:0]     w_grant_fix;
    logic [NUM_CH-1:0]     w_grant_rr;
    logic [NUM_CH-1:0]     w_grant;
    logic [SEL_WIDTH-1:0]  w_grant_idx;
    logic [WIDTH-1:0]      w_grant_data;
    logic                  w_xfer;
    logic [SEL_WIDTH-1:0]  w_rr_next;

    // The output slice can accept a word when it is empty or is being
    // drained by the consumer in this same cycle.
    assign w_load = ~r_out_valid | out_ready;

    // ------------------------------------------------------------------------
    // Fixed-select grant. A sel value with no matching channel (sel >= NUM_CH)
    // simply matches nothing, so no grant is produced.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_fix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                w_grant_fix[i] = in_valid[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin grant. Search position k visits channel (rr_ptr + k) mod
    // NUM_CH. The modulo is resolved by comparing against both i and
    // i + NUM_CH, which keeps every index constant after loop unrolling and
    // works for non-power-of-two channel counts. The first valid channel
    // found in search order wins.
    // ------------------------------------------------------------------------
    always_comb begin
        logic found;
        w_grant_rr = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && in_valid[i] &&
                    ((int'(r_rr_ptr) + k == i) ||
                     (int'(r_rr_ptr) + k == i + NUM_CH))) begin
                    w_grant_rr[i] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    assign w_grant = mode ? w_grant_rr : w_grant_fix;

    // ------------------------------------------------------------------------
    // One-hot grant to index and data. At most one bit of w_grant is set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = SEL_WIDTH'(i);
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // in_ready is forced low during reset so no producer believes a word
    // was accepted while the output stage is being cleared.
    assign in_ready = w_grant & {NUM_CH{w_load & rst_n}};
    assign w_xfer   = (|w_grant) & w_load;

    // Pointer moves to the channel after the winner, wrapping explicitly at
    // NUM_CH-1 rather than relying on the natural SEL_WIDTH overflow.
    assign w_rr_next = (w_grant_idx == SEL_WIDTH'(NUM_CH - 1)) ?
                       '0 : (w_grant_idx + 1'b1);

    // ------------------------------------------------------------------------
    // Output stage and arbitration pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            // When stalled (valid & ~ready) nothing below changes.
            if (w_load) begin
                r_out_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_out_data <= w_grant_data;
                r_out_chan <= w_grant_idx;
            end
            if (w_xfer && mode) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

`ifdef MUX_PARITY_EN
    // ------------------------------------------------------------------------
    // Optional parity, captured on the same transfers as out_data so it
    // always describes the word currently presented.
    // ------------------------------------------------------------------------
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if (w_xfer) begin
            r_out_parity <= ^w_grant_data;
        end
    end

    assign out_parity = r_out_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_stream
// Description : Scoreboard testbench for mux_nto1_stream (NUM_CH=4, WIDTH=64)
//               plus a small NUM_CH=3 instance for pointer wrap. Stimulus
//               pushes hand-computed expected words; a negedge monitor pops
//               and compares on every output handshake.
//               MUX_PARITY_EN adds parity stimulus and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_stream;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  chan;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [1:0]    sel;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [255:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [1:0]    out_chan;
`ifdef MUX_PARITY_EN
    logic          out_parity;
    logic          m3_out_parity;
`endif

    logic          m3_mode;
    logic [1:0]    m3_sel;
    logic [2:0]    m3_in_valid;
    logic [2:0]    m3_in_ready;
    logic [23:0]   m3_in_data;
    logic          m3_out_valid;
    logic          m3_out_ready;
    logic [7:0]    m3_out_data;
    logic [1:0]    m3_out_chan;

    exp_t          q[$];
    int            checks;
    int            errors;

    logic [2:0]    exp3_rdy  [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [1:0]    exp3_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    mux_nto1_stream #(
        .WIDTH     (64),
        .NUM_CH    (4),
        .SEL_WIDTH (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan)
`ifdef MUX_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    mux_nto1_stream #(
        .WIDTH     (8),
        .NUM_CH    (3),
        .SEL_WIDTH (2)
    ) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (m3_mode),
        .sel        (m3_sel),
        .in_valid   (m3_in_valid),
        .in_ready   (m3_in_ready),
        .in_data    (m3_in_data),
        .out_valid  (m3_out_valid),
        .out_ready  (m3_out_ready),
        .out_data   (m3_out_data),
        .out_chan   (m3_out_chan)
`ifdef MUX_PARITY_EN
        ,
        .out_parity (m3_out_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [63:0] d);
        in_data[i*64 +: 64] = d;
    endtask

    task automatic set_all(input logic [63:0] base);
        for (int i = 0; i < 4; i++) begin
            in_data[i*64 +: 64] = base + 64'(i);
        end
    endtask

    // One clock of directed stimulus. Inputs are applied just after the
    // rising edge; in_ready is checked once settled; if a transfer is
    // expected on the coming edge its word goes into the scoreboard.
    task automatic cycle(input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic rdy, input logic [3:0] exp_rdy,
                         input logic push, input logic [63:0] pdata,
                         input logic [1:0] pchan);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (push) q.push_back({pdata, pchan});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got chan %0d data %h, expected no word (t=%0t)",
                         out_chan, out_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_chan", 64'(out_chan), 64'(e.chan));
`ifdef MUX_PARITY_EN
                chk("out_parity", 64'(out_parity), 64'(^e.data));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        mode         = 1'b0;
        sel          = 2'd2;
        in_valid     = 4'hF;
        out_ready    = 1'b1;
        in_data      = '0;
        m3_mode      = 1'b1;
        m3_sel       = 2'd0;
        m3_in_valid  = 3'b000;
        m3_out_ready = 1'b1;
        m3_in_data   = {8'h32, 8'h31, 8'h30};

        // ---- 1. Reset state, then first fixed-select transfer ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_chan",  64'(out_chan), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        rst_n = 1'b1;
        set_ch(2, 64'hA5A5);
        cycle(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 64'hA5A5, 2'd2);
        chk("t1_out_chan", 64'(out_chan), 64'd2);
        cycle(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

        // ---- 2. Round-robin over all channels, full throughput ----
        set_all(64'h2000);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1,
                  64'h2000 + 64'(k % 4), 2'(k % 4));
            chk("rr_out_valid", 64'(out_valid), 64'd1);
        end
        cycle(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

        // ---- 3. Backpressure: word held, no loss or duplication ----
        set_ch(1, 64'h1234);
        cycle(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 64'h1234, 2'd1);
        set_ch(1, 64'h5678);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b0, 64'd0, 2'd0);
            chk("bp_out_data", out_data, 64'h1234);
        end
        cycle(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 64'h5678, 2'd1);
        cycle(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

        // ---- 4. Round-robin skip and wrap (pointer 0 -> 3 via channel 2) ----
        set_all(64'h4000);
        cycle(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 64'h4002, 2'd2);
        cycle(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1, 64'h4000, 2'd0);
        cycle(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 64'h4002, 2'd2);
        cycle(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1, 64'h4000, 2'd0);
        cycle(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

        // ---- 5. Select of an idle channel; mode switch with word pending ----
        set_all(64'h5000);
        cycle(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);
        chk("sel3_out_valid", 64'(out_valid), 64'd0);
        cycle(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 64'h5000, 2'd0);
        cycle(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b0, 64'd0, 2'd0);
        chk("sw_out_data", out_data, 64'h5000);
        chk("sw_out_chan", 64'(out_chan), 64'd0);
        cycle(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 64'h5001, 2'd1);
        cycle(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

        // ---- Reset mid-operation discards the held word ----
        set_all(64'h6000);
        cycle(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b0, 64'd0, 2'd0);
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        in_valid = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data",  out_data, 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);

`ifdef MUX_PARITY_EN
        // ---- 6. Parity of single and double set bits ----
        set_ch(0, 64'h1);
        cycle(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 64'h1, 2'd0);
        chk("par_1", 64'(out_parity), 64'd1);
        set_ch(0, 64'h3);
        cycle(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 64'h3, 2'd0);
        chk("par_3", 64'(out_parity), 64'd0);
        cycle(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0);
`endif

        // ---- NUM_CH=3: pointer wraps 2 -> 0 ----
        m3_in_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("m3_in_ready", 64'(m3_in_ready), 64'(exp3_rdy[k]));
            @(posedge clk);
            #1;
            chk("m3_out_valid", 64'(m3_out_valid), 64'd1);
            chk("m3_out_chan",  64'(m3_out_chan), 64'(exp3_chan[k]));
            chk("m3_out_data",  64'(m3_out_data), 64'(8'h30 + 8'(exp3_chan[k])));
        end
        m3_in_valid = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
